aes_block_fifo: RTL

//  Parametrised first-word-fall-through block FIFO between rx_shift and the AES core.

---
 rtl/aes_block_fifo.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/aes_block_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aes_block_fifo
//  Description : First-word-fall-through block FIFO between rx_shift and the
//                AES core. Holds WIDTH-bit blocks in a DEPTH-entry circular
//                buffer. A push and a pop can happen in the same cycle. The
//                FIFO reports its fill level and raises sticky
//                overflow/underflow flags.
//  Ports       : clk          - system clock, rising edge
//                reset        - asynchronous active-low reset
//                wr_en        - push request
//                wr_data      - block to push
//                rd_en        - pop request (consumes rd_data)
//                rd_data      - head-of-queue block, valid while empty==0
//                empty        - no readable data
//                full         - level == DEPTH
//                level        - occupancy 0..DEPTH
//                overflow     - sticky: push dropped while full
//                underflow    - sticky: pop requested while empty
//                clr_err      - synchronous clear of overflow/underflow
//                almost_full  - level >= AF_LVL  (FIFO_THRESH_EN only)
//                almost_empty - level <= AE_LVL  (FIFO_THRESH_EN only)
//  Config      : define FIFO_THRESH_EN to add almost_full/almost_empty
//  Revision    : 1.0 - initial release, replaces fixed 7-entry block buffer
// ============================================================================
module aes_block_fifo #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [$clog2(DEPTH):0] level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
`ifdef FIFO_THRESH_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH_LVL = (AW+1)'(DEPTH);

  // Storage is intentionally left without reset; reset only clears pointers.
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra MSB so that full and empty can be told apart.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_empty;
  logic             r_full;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;
  logic [AW:0]      w_level_nxt;
  logic [WIDTH-1:0] w_rd_data_nxt;

  // When full, a simultaneous pop frees the slot being written.
  assign w_push    = wr_en && (!r_full || rd_en);
  assign w_pop     = rd_en && !r_empty;
  assign w_ovf_evt = wr_en && r_full && !rd_en;
  assign w_udf_evt = rd_en && r_empty;

  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  // The next head is the block being written this cycle when the queue would
  // otherwise be empty after the pop; the memory write is not visible yet,
  // so bypass it.
  always_comb begin
    w_rd_data_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
    if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_rd_data_nxt = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_empty  <= (w_level_nxt == '0);
      r_full   <= (w_level_nxt == c_DEPTH_LVL);
      // rd_data only moves when the head moves, so it holds across idle
      // cycles and ignored pops.
      if (w_push || w_pop) begin
        r_rd_data <= w_rd_data_nxt;
      end
      // A new error event takes priority over a coincident clear.
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign empty     = r_empty;
  assign full      = r_full;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef FIFO_THRESH_EN
  localparam logic [AW:0] c_AF_LVL = (AW+1)'(AF_LVL);
  localparam logic [AW:0] c_AE_LVL = (AW+1)'(AE_LVL);

  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_level_nxt >= c_AF_LVL);
      r_almost_empty <= (w_level_nxt <= c_AE_LVL);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

endmodule
`default_nettype wire
